csa_accumulator: RTL and testbench

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_accumulator.sv | 109 ++++++++++
 tb/tb_csa_accumulator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// Carry-save group accumulator: sums operand groups with one 3:2 level
// per operand and resolves the redundant pair once per group.
module csa_accumulator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+CNT_W-1:0] out_sum,
  output logic [CNT_W:0]         out_count,
  output logic                   out_trunc
);

  localparam int OUT_W = WIDTH + CNT_W;
  localparam logic [CNT_W:0] MAX_CNT = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ACCUM,
    RESOLVE,
    HOLD
  } state_t;

  state_t state;
  state_t state_n;

  logic [OUT_W-1:0] s_q;
  logic [OUT_W-1:0] c_q;
  logic [OUT_W-1:0] d_ext;
  logic [OUT_W-1:0] s_csa;
  logic [OUT_W-1:0] maj;
  logic [OUT_W-1:0] c_csa;
  logic [CNT_W:0]   cnt_q;
  logic [CNT_W:0]   cnt_inc;
  logic             accept;
  logic             produce;
  logic             close;

  // One 3:2 compressor level; carry vector shifts into the next weight
  assign d_ext   = {{CNT_W{1'b0}}, in_data};
  assign s_csa   = s_q ^ c_q ^ d_ext;
  assign maj     = (s_q & c_q) | (s_q & d_ext) | (c_q & d_ext);
  assign c_csa   = {maj[OUT_W-2:0], 1'b0};
  assign cnt_inc = cnt_q + ONE;

  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign produce   = out_valid && out_ready;
  assign close     = accept && (in_last || (cnt_inc == MAX_CNT));

  always_comb begin
    state_n = state;
    unique case (state)
      ACCUM:   if (close) state_n = RESOLVE;
      RESOLVE: state_n = HOLD;
      HOLD:    if (produce) state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      c_q   <= '0;
      cnt_q <= '0;
    end else if (produce) begin
      s_q   <= '0;
      c_q   <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      s_q   <= s_csa;
      c_q   <= c_csa;
      cnt_q <= cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum   <= '0;
      out_count <= '0;
      out_trunc <= 1'b0;
    end else begin
      if (close) begin
        out_trunc <= !in_last;
      end
      // The only carry-propagate add, once per group
      if (state == RESOLVE) begin
        out_sum   <= s_q + c_q;
        out_count <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed checks on the default build plus a randomized scoreboard run
// on a WIDTH=16, CNT_W=3 build.
module tb_csa_accumulator;

  logic clk;
  logic rst;

  logic        a_in_valid;
  logic        a_in_ready;
  logic [7:0]  a_in_data;
  logic        a_in_last;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [11:0] a_out_sum;
  logic [4:0]  a_out_count;
  logic        a_out_trunc;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [15:0] b_in_data;
  logic        b_in_last;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [18:0] b_out_sum;
  logic [3:0]  b_out_count;
  logic        b_out_trunc;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int sum;
    int cnt;
    bit trunc;
  } grp_t;

  grp_t exp_q[$];
  int   pushed = 0;
  int   got = 0;
  bit   pdone = 0;

  csa_accumulator u_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_last   (a_in_last),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_sum   (a_out_sum),
    .out_count (a_out_count),
    .out_trunc (a_out_trunc)
  );

  csa_accumulator #(.WIDTH(16), .CNT_W(3)) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_last   (b_in_last),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum),
    .out_count (b_out_count),
    .out_trunc (b_out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic l);
    int n;
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_last  = l;
    n = 0;
    while (!a_in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("a_send_ready", a_in_ready, 1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic produce_a();
    @(negedge clk);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    chk("a_ready_after_produce", a_in_ready, 1);
    chk("a_valid_after_produce", a_out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_sum", a_out_sum, 0);
    chk("rst_out_count", a_out_count, 0);
    chk("rst_out_trunc", a_out_trunc, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", a_in_ready, 1);

    // 3 + 5 + 7
    send_a(8'd3, 1'b0);
    send_a(8'd5, 1'b0);
    send_a(8'd7, 1'b1);
    chk("g1_valid_t1", a_out_valid, 0);
    chk("g1_ready_t1", a_in_ready, 0);
    @(posedge clk);
    #1;
    chk("g1_valid_t2", a_out_valid, 1);
    chk("g1_sum", a_out_sum, 15);
    chk("g1_count", a_out_count, 3);
    chk("g1_trunc", a_out_trunc, 0);
    produce_a();

    // 16 x 255, never last: truncated group
    for (int i = 0; i < 16; i++) send_a(8'd255, 1'b0);
    chk("g2_ready_full", a_in_ready, 0);
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_data  = 8'd1;
    a_in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("g2_held_off", a_in_ready, 0);
      @(negedge clk);
    end
    chk("g2_valid", a_out_valid, 1);
    chk("g2_sum", a_out_sum, 4080);
    chk("g2_count", a_out_count, 16);
    chk("g2_trunc", a_out_trunc, 1);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    chk("g2_ready_after_produce", a_in_ready, 1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    @(posedge clk);
    #1;
    chk("g3_valid", a_out_valid, 1);
    chk("g3_sum", a_out_sum, 1);
    chk("g3_count", a_out_count, 1);
    chk("g3_trunc", a_out_trunc, 0);
    produce_a();

    // single 0xAA held for 5 cycles
    send_a(8'hAA, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("g4_valid_hold", a_out_valid, 1);
      chk("g4_sum_hold", a_out_sum, 170);
      chk("g4_count_hold", a_out_count, 1);
      chk("g4_ready_hold", a_in_ready, 0);
    end
    produce_a();

    // reset discards a partial group
    send_a(8'd9, 1'b0);
    send_a(8'd9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("g5_ready_in_rst", a_in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("g5_valid_after_rst", a_out_valid, 0);
    chk("g5_ready_after_rst", a_in_ready, 1);
    send_a(8'd1, 1'b0);
    send_a(8'd1, 1'b1);
    @(posedge clk);
    #1;
    chk("g5_sum", a_out_sum, 2);
    chk("g5_count", a_out_count, 2);
    chk("g5_trunc", a_out_trunc, 0);
    produce_a();

    // reset in HOLD drops the pending result
    send_a(8'd4, 1'b1);
    @(posedge clk);
    #1;
    chk("g6_valid_before_rst", a_out_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("g6_no_output", a_out_valid, 0);
    end
    chk("g6_sum_cleared", a_out_sum, 0);
    chk("g6_count_cleared", a_out_count, 0);

    // randomized groups on the 16-bit build
    fork
      begin
        int acc;
        int cnt;
        int n;
        logic [15:0] d;
        logic l;
        acc = 0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            b_in_valid = 1'b0;
          end
          @(negedge clk);
          d = 16'($urandom);
          l = (i == 299) || ($urandom_range(0, 6) == 0);
          b_in_valid = 1'b1;
          b_in_data  = d;
          b_in_last  = l;
          n = 0;
          while (!b_in_ready && n < 40) begin
            @(negedge clk);
            n++;
          end
          chk("b_send_ready", b_in_ready, 1);
          @(posedge clk);
          acc += int'(d);
          cnt++;
          if (l || cnt == 8) begin
            exp_q.push_back('{sum: acc, cnt: cnt, trunc: !l});
            pushed++;
            acc = 0;
            cnt = 0;
          end
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        pdone = 1'b1;
      end
      begin
        grp_t g;
        for (int k = 0; k < 20000; k++) begin
          @(negedge clk);
          if (pdone && exp_q.size() == 0) break;
          b_out_ready = 1'($urandom_range(0, 1));
          if (b_out_valid && b_out_ready) begin
            chk("b_not_dup", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              g = exp_q.pop_front();
              got++;
              chk("b_sum", b_out_sum, g.sum);
              chk("b_count", b_out_count, g.cnt);
              chk("b_trunc", b_out_trunc, g.trunc);
            end
          end
        end
        @(negedge clk);
        b_out_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    chk("b_drained", exp_q.size(), 0);
    chk("b_groups", got, pushed);
    chk("b_idle_valid", b_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
